// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Constants and types shared by the 001011 sequence generator and the frame
// aligner (seq_frame_sync, seq_window_match).
// -----------------------------------------------------------------------------
package seq_pkg;

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      CHECK = 2'd1,
      LOCK  = 2'd2
   } state_t;

   localparam int                       PAT_LEN_DEF = 6;
   localparam logic [PAT_LEN_DEF-1:0]   PAT_DEF     = 6'b001011;

   // 8-bit increment that sticks at 255.
   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/seq_window_match.sv
// -----------------------------------------------------------------------------
// seq_window_match
// PAT_LEN-bit serial window with a fill counter and pattern comparator.
//
// Ports
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   valid_i  din_i is taken only when high
//   din_i    serial data bit (first-received bit ends up in the MSB)
//   hit_o    the window *including the bit presented this cycle* equals
//            PATTERN and at least PAT_LEN valid bits have been seen since reset.
//            Combinational so the parent can register it on the same edge that
//            takes the bit; always 0 when valid_i is low.
// -----------------------------------------------------------------------------
module seq_window_match
   import seq_pkg::*;
#(
   parameter int                 PAT_LEN = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN = PAT_LEN'(PAT_DEF)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic valid_i,
   input  logic din_i,
   output logic hit_o
);

   localparam logic [3:0] FILL_FULL = 4'(PAT_LEN);

   logic [PAT_LEN-1:0] sr_q, sr_d;
   logic [3:0]         fill_q, fill_d;

   always_comb begin
      sr_d   = sr_q;
      fill_d = fill_q;
      if (valid_i) begin
         sr_d = {sr_q[PAT_LEN-2:0], din_i};
         if (fill_q != FILL_FULL) begin
            fill_d = fill_q + 4'd1;
         end
      end
      hit_o = valid_i && (fill_d == FILL_FULL) && (sr_d == PATTERN);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr_q   <= '0;
         fill_q <= '0;
      end else begin
         sr_q   <= sr_d;
         fill_q <= fill_d;
      end
   end

endmodule

// File: rtl/seq_frame_sync.sv
// -----------------------------------------------------------------------------
// seq_frame_sync
// Serial frame aligner for the periodic 001011 sequence. Hunts for the
// pattern, confirms LOCK_CNT period-aligned matches, then tracks bit phase and
// counts boundary mismatches until LOSS_CNT consecutive misses drop lock.
//
// Ports
//   clk        system clock
//   rst        synchronous active-high reset
//   din_valid  din is sampled only when high
//   din        serial data bit
//   match      1-cycle pulse: last PAT_LEN valid bits equal PATTERN
//   locked     high while in LOCK
//   phase      bit position within the frame while locked, else 0
//   err_pulse  1-cycle pulse on each boundary mismatch while locked
//   err_cnt    saturating count of err_pulse events (cleared by rst only)
//
// state | meaning
// ------+---------------------------------------------------------------
// HUNT  | searching; any valid bit completing a match anchors the frame
// CHECK | anchored; confirming matches on successive frame boundaries
// LOCK  | aligned; boundary mismatches raise err_pulse and count toward loss
// -----------------------------------------------------------------------------
module seq_frame_sync
   import seq_pkg::*;
#(
   parameter int                 PAT_LEN  = PAT_LEN_DEF,
   parameter logic [PAT_LEN-1:0] PATTERN  = PAT_LEN'(PAT_DEF),
   parameter int                 LOCK_CNT = 3,
   parameter int                 LOSS_CNT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       din_valid,
   input  logic       din,
   output logic       match,
   output logic       locked,
   output logic [2:0] phase,
   output logic       err_pulse,
   output logic [7:0] err_cnt
);

   localparam logic [2:0] FC_LAST   = 3'(PAT_LEN - 1);
   localparam logic [7:0] LOCK_GOAL = 8'(LOCK_CNT);
   localparam logic [7:0] LOSS_GOAL = 8'(LOSS_CNT);

   logic hit;

   seq_window_match #(
      .PAT_LEN (PAT_LEN),
      .PATTERN (PATTERN)
   ) u_window (
      .clk_i   (clk),
      .rst_i   (rst),
      .valid_i (din_valid),
      .din_i   (din),
      .hit_o   (hit)
   );

   state_t     state_q, state_d;
   logic [2:0] fc_q, fc_d;
   logic [7:0] good_q, good_d;
   logic [7:0] bad_q, bad_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       err_d;
   logic       boundary;
   logic [2:0] phase_d;

   logic       match_q, locked_q, err_pulse_q;
   logic [2:0] phase_q;

   always_comb begin
      state_d   = state_q;
      fc_d      = fc_q;
      good_d    = good_q;
      bad_d     = bad_q;
      err_cnt_d = err_cnt_q;
      err_d     = 1'b0;
      boundary  = (fc_q == FC_LAST);

      if (din_valid) begin
         fc_d = boundary ? 3'd0 : fc_q + 3'd1;

         unique case (state_q)
            HUNT: begin
               // The matching bit itself is position 0 of the new frame, so
               // the next boundary falls exactly PAT_LEN valid bits later.
               if (hit) begin
                  state_d = CHECK;
                  fc_d    = 3'd0;
                  good_d  = 8'd1;
               end
            end
            CHECK: begin
               if (boundary) begin
                  if (hit) begin
                     good_d = good_q + 8'd1;
                     if (good_q + 8'd1 == LOCK_GOAL) begin
                        state_d = LOCK;
                        bad_d   = 8'd0;
                     end
                  end else begin
                     state_d = HUNT;
                     good_d  = 8'd0;
                  end
               end
            end
            LOCK: begin
               if (boundary) begin
                  if (hit) begin
                     bad_d = 8'd0;
                  end else begin
                     err_d     = 1'b1;
                     err_cnt_d = sat_inc8(err_cnt_q);
                     bad_d     = bad_q + 8'd1;
                     if (bad_q + 8'd1 == LOSS_GOAL) begin
                        state_d = HUNT;
                        good_d  = 8'd0;
                     end
                  end
               end
            end
            default: begin
               state_d = HUNT;
               good_d  = 8'd0;
            end
         endcase
      end

      phase_d = (state_d == LOCK) ? fc_d : 3'd0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HUNT;
         fc_q        <= '0;
         good_q      <= '0;
         bad_q       <= '0;
         err_cnt_q   <= '0;
         match_q     <= 1'b0;
         locked_q    <= 1'b0;
         phase_q     <= '0;
         err_pulse_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         fc_q        <= fc_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         err_cnt_q   <= err_cnt_d;
         match_q     <= hit;
         locked_q    <= (state_d == LOCK);
         phase_q     <= phase_d;
         err_pulse_q <= err_d;
      end
   end

   assign match     = match_q;
   assign locked    = locked_q;
   assign phase     = phase_q;
   assign err_pulse = err_pulse_q;
   assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_seq_frame_sync.sv
module tb_seq_frame_sync;
   import seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       din_valid;
   logic       din;
   logic       match;
   logic       locked;
   logic [2:0] phase;
   logic       err_pulse;
   logic [7:0] err_cnt;

   int checks   = 0;
   int failures = 0;

   seq_frame_sync dut (
      .clk       (clk),
      .rst       (rst),
      .din_valid (din_valid),
      .din       (din),
      .match     (match),
      .locked    (locked),
      .phase     (phase),
      .err_pulse (err_pulse),
      .err_cnt   (err_cnt)
   );

   always #5 clk = ~clk;

   // reference model: bit history plus an anchor bit index; frame
   // boundaries are every 6th valid bit after the anchor
   logic [5:0] pat_v;
   int m_n, m_anchor, m_good, m_bad, m_errs, m_phase, m_mode; // mode: 0 hunt,1 check,2 lock
   int m_win[$];
   int g;
   int first_match_n, first_lock_n;

   task automatic check_eq(input string tag, input int obs, input int exp);
      checks++;
      if (obs != exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_n = 0; m_anchor = 0; m_good = 0; m_bad = 0; m_errs = 0;
      m_phase = 0; m_mode = 0;
      m_win.delete();
      g = 0;
      first_match_n = -1;
      first_lock_n  = -1;
   endtask

   task automatic step(input logic v, input logic b);
      int  em, ee, off;
      bit  hitm;
      din_valid = v;
      din       = b;
      @(posedge clk);
      #1;
      em = 0;
      ee = 0;
      if (v) begin
         m_n++;
         m_win.push_back(int'(b));
         if (m_win.size() > 6) void'(m_win.pop_front());
         hitm = (m_win.size() == 6);
         if (hitm) begin
            for (int i = 0; i < 6; i++) begin
               if (m_win[i] != int'(pat_v[5-i])) hitm = 1'b0;
            end
         end
         em  = int'(hitm);
         off = (m_n - m_anchor) % 6;
         if (m_mode == 0) begin
            if (hitm) begin
               m_mode = 1; m_anchor = m_n; m_good = 1;
            end
         end else if (off == 0) begin
            if (m_mode == 1) begin
               if (hitm) begin
                  m_good++;
                  if (m_good == 3) begin m_mode = 2; m_bad = 0; end
               end else begin
                  m_mode = 0;
               end
            end else begin
               if (hitm) m_bad = 0;
               else begin
                  ee = 1;
                  if (m_errs < 255) m_errs++;
                  m_bad++;
                  if (m_bad == 2) m_mode = 0;
               end
            end
         end
         m_phase = (m_mode == 2) ? (m_n - m_anchor) % 6 : 0;
      end
      check_eq("match",     int'(match),     em);
      check_eq("err_pulse", int'(err_pulse), ee);
      check_eq("locked",    int'(locked),    int'(m_mode == 2));
      check_eq("phase",     int'(phase),     m_phase);
      check_eq("err_cnt",   int'(err_cnt),   m_errs);
      if (match  && first_match_n < 0) first_match_n = m_n;
      if (locked && first_lock_n  < 0) first_lock_n  = m_n;
   endtask

   task automatic do_reset();
      rst = 1'b1; din_valid = 1'b1; din = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0; din_valid = 1'b0;
      model_reset();
      check_eq("rst_match",     int'(match),     0);
      check_eq("rst_locked",    int'(locked),    0);
      check_eq("rst_phase",     int'(phase),     0);
      check_eq("rst_err_pulse", int'(err_pulse), 0);
      check_eq("rst_err_cnt",   int'(err_cnt),   0);
   endtask

   task automatic send_gen(input bit flip);
      logic b;
      b = pat_v[5 - (g % 6)];
      if (flip) b = ~b;
      step(1'b1, b);
      g++;
   endtask

   // whole frames from the generator; optionally flip bit 2 of each frame
   task automatic send_frames(input int k, input bit flip);
      for (int f = 0; f < k; f++)
         for (int i = 0; i < 6; i++) send_gen(flip && (i == 2));
   endtask

   task automatic gap(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'($urandom));
   endtask

   initial begin
      pat_v = PAT_DEF;
      rst = 1'b0; din_valid = 1'b0; din = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);

      // clean aligned stream
      do_reset();
      send_frames(5, 1'b0);
      check_eq("s1_first_match", first_match_n, 6);
      check_eq("s1_first_lock",  first_lock_n, 18);

      // leading garbage 111
      do_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
      send_frames(5, 1'b0);
      check_eq("s2_first_match", first_match_n, 9);
      check_eq("s2_first_lock",  first_lock_n, 21);

      // isolated corrupted frames keep lock
      send_frames(1, 1'b1);
      check_eq("s3_locked",  int'(locked),  1);
      check_eq("s3_err_cnt", int'(err_cnt), 1);
      send_frames(2, 1'b0);
      send_frames(1, 1'b1);
      check_eq("s3_locked2",  int'(locked),  1);
      check_eq("s3_err_cnt2", int'(err_cnt), 2);

      // two consecutive corrupted frames drop lock, re-lock keeps err_cnt
      send_frames(1, 1'b0);
      send_frames(2, 1'b1);
      check_eq("s4_unlocked", int'(locked),  0);
      check_eq("s4_err_cnt",  int'(err_cnt), 4);
      send_frames(4, 1'b0);
      check_eq("s4_relocked",     int'(locked),  1);
      check_eq("s4_err_cnt_kept", int'(err_cnt), 4);

      // random valid gaps: timing in valid-bit count unchanged
      do_reset();
      for (int i = 0; i < 40; i++) begin
         send_gen(1'b0);
         gap($urandom_range(0, 3));
      end
      check_eq("s5_first_match", first_match_n, 6);
      check_eq("s5_first_lock",  first_lock_n, 18);

      // reset while locked with err_cnt = 5
      do_reset();
      send_frames(4, 1'b0);
      for (int i = 0; i < 5; i++) begin
         send_frames(1, 1'b1);
         send_frames(1, 1'b0);
      end
      check_eq("s6_err_cnt", int'(err_cnt), 5);
      check_eq("s6_locked",  int'(locked),  1);
      do_reset();
      send_frames(2, 1'b0);
      check_eq("s6_refill_match", first_match_n, 6);

      // randomized generator stream with sparse bit errors and random gaps
      do_reset();
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) != 0) send_gen($urandom_range(0, 24) == 0);
         else step(1'b0, 1'($urandom));
      end

      // fully random input
      for (int i = 0; i < 150; i++) step(1'($urandom), 1'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
